store_buffer: RTL and testbench

Write-through store buffer for the data side. It queues CPU stores (address, byte select, data) from the MEM stage and presents the oldest entry to the data-side Wishbone arbiter, which drains it to memory. It merges back-to-back stores to the same word and forwards buffered data to loads. It asserts full to stall the pipeline.

---
 rtl/store_buffer.sv | 123 ++++++++++++
 tb/tb_store_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Write-through data-side store buffer: queues CPU stores for the Wishbone arbiter,
// merges same-word stores into the youngest entry and forwards buffered data to loads.
module store_buffer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid_i,
    input  logic [31:0]   st_addr_i,
    input  logic [3:0]    st_sel_i,
    input  logic [31:0]   st_data_i,
    output logic          st_ready_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic [31:0]   head_addr_o,
    output logic [3:0]    head_sel_o,
    output logic [31:0]   head_data_o,
    input  logic          pop_i,
    input  logic [31:0]   ld_addr_i,
    output logic          ld_hit_o,
    output logic [3:0]    ld_sel_o,
    output logic [31:0]   ld_data_o,
    output logic          ld_full_hit_o
);

    logic [29:0]      ent_addr [DEPTH];
    logic [3:0]       ent_sel  [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] yng_ptr;
    logic [AW:0]   count;

    logic st_req;
    logic merge;
    logic alloc;
    logic pop;

    logic [AW-1:0] fwd_idx;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{st_addr_i[1:0], ld_addr_i[1:0]};

    assign full_o     = (count == (AW+1)'(DEPTH));
    assign empty_o    = (count == '0);
    assign st_ready_o = !full_o;
    assign count_o    = count;

    // Merge targets only the youngest entry, and never the head (count >= 2)
    assign yng_ptr = wr_ptr - AW'(1);
    assign st_req  = st_valid_i && (st_sel_i != 4'b0000);
    assign merge   = st_req && (count >= (AW+1)'(2)) && ent_valid[yng_ptr]
                     && (ent_addr[yng_ptr] == st_addr_i[31:2]);
    assign alloc   = st_req && !merge && !full_o;
    assign pop     = pop_i && !empty_o;

    // Pointer, count and valid-bit bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (alloc) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + AW'(1);
            end
            case ({alloc, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload; only ever read through valid bits, so it needs no reset
    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_addr[wr_ptr] <= st_addr_i[31:2];
            ent_sel[wr_ptr]  <= st_sel_i;
            ent_data[wr_ptr] <= st_data_i;
        end else if (merge) begin
            ent_sel[yng_ptr] <= ent_sel[yng_ptr] | st_sel_i;
            for (int n = 0; n < 4; n++) begin
                if (st_sel_i[n]) begin
                    ent_data[yng_ptr][8*n +: 8] <= st_data_i[8*n +: 8];
                end
            end
        end
    end

    assign head_addr_o = empty_o ? 32'h0 : {ent_addr[rd_ptr], 2'b00};
    assign head_sel_o  = empty_o ? 4'h0  : ent_sel[rd_ptr];
    assign head_data_o = empty_o ? 32'h0 : ent_data[rd_ptr];

    // Walk oldest to youngest so the last match seen is the youngest
    always_comb begin
        ld_hit_o  = 1'b0;
        ld_sel_o  = 4'h0;
        ld_data_o = 32'h0;
        fwd_idx   = rd_ptr;
        for (int i = 0; i < int'(DEPTH); i++) begin
            fwd_idx = rd_ptr + AW'(i);
            if (ent_valid[fwd_idx] && (ent_addr[fwd_idx] == ld_addr_i[31:2])) begin
                ld_hit_o  = 1'b1;
                ld_sel_o  = ent_sel[fwd_idx];
                ld_data_o = ent_data[fwd_idx];
            end
        end
    end

    assign ld_full_hit_o = ld_hit_o && (ld_sel_o == 4'b1111);

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: push/pop, merge, full/wrap,
// head-merge exclusion, youngest-match forwarding and mid-traffic reset.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid_i;
    logic [31:0] st_addr_i;
    logic [3:0]  st_sel_i;
    logic [31:0] st_data_i;
    logic        st_ready_o;
    logic        full_o;
    logic        empty_o;
    logic [5:0]  count_o;
    logic [31:0] head_addr_o;
    logic [3:0]  head_sel_o;
    logic [31:0] head_data_o;
    logic        pop_i;
    logic [31:0] ld_addr_i;
    logic        ld_hit_o;
    logic [3:0]  ld_sel_o;
    logic [31:0] ld_data_o;
    logic        ld_full_hit_o;

    int errors = 0;
    int checks = 0;

    store_buffer #(.DEPTH(32), .AW(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid_i    (st_valid_i),
        .st_addr_i     (st_addr_i),
        .st_sel_i      (st_sel_i),
        .st_data_i     (st_data_i),
        .st_ready_o    (st_ready_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .count_o       (count_o),
        .head_addr_o   (head_addr_o),
        .head_sel_o    (head_sel_o),
        .head_data_o   (head_data_o),
        .pop_i         (pop_i),
        .ld_addr_i     (ld_addr_i),
        .ld_hit_o      (ld_hit_o),
        .ld_sel_o      (ld_sel_o),
        .ld_data_o     (ld_data_o),
        .ld_full_hit_o (ld_full_hit_o)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        st_valid_i = 1'b1; st_addr_i = a; st_sel_i = s; st_data_i = d;
        tick();
        st_valid_i = 1'b0;
    endtask

    task automatic pop_one();
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
    endtask

    task automatic look(input logic [31:0] a);
        ld_addr_i = a;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        look(32'h0);
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full_o); end
        checks++; if (st_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", st_ready_o); end
        checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
        checks++; if ({head_addr_o, head_sel_o, head_data_o} !== 68'h0) begin errors++; $display("FAIL reset_head: got %h/%h/%h want 0", head_addr_o, head_sel_o, head_data_o); end
        checks++; if ({ld_hit_o, ld_sel_o, ld_data_o, ld_full_hit_o} !== 38'h0) begin errors++; $display("FAIL reset_ld: got hit=%b sel=%h data=%h want 0", ld_hit_o, ld_sel_o, ld_data_o); end
    endtask

    task automatic test_push_pop();
        push(32'h100, 4'hF, 32'hDEADBEEF);
        checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b want 0", empty_o); end
        checks++; if (count_o !== 6'd1) begin errors++; $display("FAIL pp_count: got %0d want 1", count_o); end
        checks++; if (head_addr_o !== 32'h100) begin errors++; $display("FAIL pp_head_addr: got %h want 00000100", head_addr_o); end
        checks++; if (head_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL pp_head_data: got %h want deadbeef", head_data_o); end
        checks++; if (head_sel_o !== 4'hF) begin errors++; $display("FAIL pp_head_sel: got %h want f", head_sel_o); end
        pop_one();
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL pp_pop_empty: got %b want 1", empty_o); end
        checks++; if ({head_addr_o, head_sel_o, head_data_o} !== 68'h0) begin errors++; $display("FAIL pp_pop_head: got %h/%h/%h want 0", head_addr_o, head_sel_o, head_data_o); end
        pop_one();
        checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL pp_pop_when_empty: got %0d want 0", count_o); end
    endtask

    task automatic test_merge();
        push(32'h200, 4'hF, 32'h11111111);
        push(32'h300, 4'h3, 32'h0000AAAA);
        push(32'h300, 4'hC, 32'hBBBB0000);
        look(32'h300);
        checks++; if (count_o !== 6'd2) begin errors++; $display("FAIL merge_count: got %0d want 2", count_o); end
        checks++; if (ld_hit_o !== 1'b1) begin errors++; $display("FAIL merge_hit: got %b want 1", ld_hit_o); end
        checks++; if (ld_sel_o !== 4'hF) begin errors++; $display("FAIL merge_sel: got %h want f", ld_sel_o); end
        checks++; if (ld_data_o !== 32'hBBBBAAAA) begin errors++; $display("FAIL merge_data: got %h want bbbbaaaa", ld_data_o); end
        checks++; if (ld_full_hit_o !== 1'b1) begin errors++; $display("FAIL merge_full_hit: got %b want 1", ld_full_hit_o); end
        checks++; if (head_addr_o !== 32'h200) begin errors++; $display("FAIL merge_head: got %h want 00000200", head_addr_o); end
        // A zero byte-select request is dropped
        push(32'h900, 4'h0, 32'h12345678);
        checks++; if (count_o !== 6'd2) begin errors++; $display("FAIL drop_sel0: got %0d want 2", count_o); end
        pop_one();
        pop_one();
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL merge_drain: got %b want 1", empty_o); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 32; i++) push(32'h1000 + 32'(i*4), 4'hF, 32'hC0DE0000 + 32'(i));
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", full_o); end
        checks++; if (st_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", st_ready_o); end
        checks++; if (count_o !== 6'd32) begin errors++; $display("FAIL full_count: got %0d want 32", count_o); end
        st_valid_i = 1'b1; st_addr_i = 32'h2000; st_sel_i = 4'hF; st_data_i = 32'hFFFF0033;
        pop_i = 1'b1;
        tick();
        st_valid_i = 1'b0; pop_i = 1'b0;
        checks++; if (count_o !== 6'd31) begin errors++; $display("FAIL full_push_pop: got %0d want 31", count_o); end
        for (int i = 1; i < 32; i++) begin
            checks++;
            if (head_addr_o !== 32'h1000 + 32'(i*4) || head_data_o !== 32'hC0DE0000 + 32'(i)) begin
                errors++;
                $display("FAIL wrap_order_%0d: got %h/%h want %h/%h", i, head_addr_o, head_data_o,
                         32'h1000 + 32'(i*4), 32'hC0DE0000 + 32'(i));
            end
            pop_one();
        end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty_o); end
    endtask

    task automatic test_no_merge_head();
        push(32'h400, 4'hF, 32'h1);
        st_valid_i = 1'b1; st_addr_i = 32'h400; st_sel_i = 4'h1; st_data_i = 32'h2;
        pop_i = 1'b1;
        tick();
        st_valid_i = 1'b0; pop_i = 1'b0;
        checks++; if (count_o !== 6'd1) begin errors++; $display("FAIL nmh_count: got %0d want 1", count_o); end
        checks++; if (head_data_o !== 32'h2 || head_sel_o !== 4'h1) begin errors++; $display("FAIL nmh_head: got %h/%h want 00000002/1", head_data_o, head_sel_o); end
        // Same word again with count==1: allocates rather than touching the head
        push(32'h400, 4'h2, 32'h300);
        look(32'h400);
        checks++; if (count_o !== 6'd2) begin errors++; $display("FAIL nmh_count2: got %0d want 2", count_o); end
        checks++; if (head_data_o !== 32'h2 || head_sel_o !== 4'h1) begin errors++; $display("FAIL nmh_head_stable: got %h/%h want 00000002/1", head_data_o, head_sel_o); end
        checks++; if (ld_sel_o !== 4'h2 || ld_data_o !== 32'h300) begin errors++; $display("FAIL nmh_fwd: got %h/%h want 2/00000300", ld_sel_o, ld_data_o); end
        pop_one();
        pop_one();
    endtask

    task automatic test_forward_youngest();
        push(32'h500, 4'hF, 32'hA);
        push(32'h600, 4'hF, 32'hB);
        push(32'h500, 4'h3, 32'h0000000C);
        look(32'h500);
        checks++; if (count_o !== 6'd3) begin errors++; $display("FAIL fwd_count: got %0d want 3", count_o); end
        checks++; if (ld_hit_o !== 1'b1) begin errors++; $display("FAIL fwd_hit: got %b want 1", ld_hit_o); end
        checks++; if (ld_data_o !== 32'h0000000C) begin errors++; $display("FAIL fwd_data: got %h want 0000000c", ld_data_o); end
        checks++; if (ld_sel_o !== 4'h3) begin errors++; $display("FAIL fwd_sel: got %h want 3", ld_sel_o); end
        checks++; if (ld_full_hit_o !== 1'b0) begin errors++; $display("FAIL fwd_full_hit: got %b want 0", ld_full_hit_o); end
        look(32'h604);
        checks++; if (ld_hit_o !== 1'b0) begin errors++; $display("FAIL fwd_miss: got %b want 0", ld_hit_o); end
    endtask

    task automatic test_reset_mid();
        push(32'h700, 4'hF, 32'h7);
        push(32'h800, 4'hF, 32'h8);
        checks++; if (count_o !== 6'd5) begin errors++; $display("FAIL rst_mid_pre: got %0d want 5", count_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        look(32'h500);
        checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b want 1", empty_o); end
        checks++; if (ld_hit_o !== 1'b0) begin errors++; $display("FAIL rst_mid_hit500: got %b want 0", ld_hit_o); end
        look(32'h800);
        checks++; if (ld_hit_o !== 1'b0) begin errors++; $display("FAIL rst_mid_hit800: got %b want 0", ld_hit_o); end
    endtask

    initial begin
        rst = 1'b1; st_valid_i = 1'b0; st_addr_i = '0; st_sel_i = '0; st_data_i = '0;
        pop_i = 1'b0; ld_addr_i = '0;
        test_reset();
        test_push_pop();
        test_merge();
        test_full_wrap();
        test_no_merge_head();
        test_forward_youngest();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
